uart_mem_bridge: RTL and testbench

Byte-command bridge between the UART receiver/transmitter and the DDR3 memory port. It parses read/write commands arriving as UART bytes and drives the `ddr3_dev` request interface (`addr`/`data`/`we`/`rd`/`ack`). It returns read data or a write acknowledgement over the UART transmitter. It replaces the free-running test counter at SoC level, so a host can load and inspect DDR3 memory.

---
 rtl/uart_mem_bridge.sv | 174 +++++++++++++++++
 tb/tb_uart_mem_bridge.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: parses 'W'/'R' byte commands from the UART receiver,
// issues one request on the DDR3 port and returns either 'K' or four bytes
// of read data through the UART transmitter.
// Optional build macro: UART_BRIDGE_TIMEOUT_EN abandons partial commands
// after TIMEOUT_CYCLES clocks without a received byte.
module uart_mem_bridge #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_sent,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic        mem_ack,
  output logic        busy,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    ST_INIT = 4'd0,
    ST_IDLE = 4'd1,
    ST_ADDR = 4'd2,
    ST_DATA = 4'd3,
    ST_EXEC = 4'd4,
    ST_TX   = 4'd5,
    ST_TXW  = 4'd6
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RESP_OK   = 8'h4B;

  state_t      state_reg, state_next;
  logic        op_write_reg, op_write_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] resp_reg, resp_next;
  logic [2:0]  resp_cnt_reg, resp_cnt_next;
  logic        timeout_hit;

`ifdef UART_BRIDGE_TIMEOUT_EN
  logic [31:0] gap_reg, gap_next;

  // Gap counter runs only while a command is partially received.
  always_comb begin
    gap_next    = 32'd0;
    timeout_hit = 1'b0;
    if ((state_reg == ST_ADDR) || (state_reg == ST_DATA)) begin
      if (!rx_valid) begin
        gap_next    = gap_reg + 32'd1;
        timeout_hit = (gap_reg == TIMEOUT_CYCLES - 32'd1);
      end
    end
  end

  // Gap counter register.
  always_ff @(posedge clk) begin
    if (!rstn) gap_reg <= 32'd0;
    else       gap_reg <= gap_next;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  // Next-state and datapath updates; received bytes outside IDLE/ADDR/DATA
  // are simply not looked at, so they are dropped rather than queued.
  always_comb begin
    state_next    = state_reg;
    op_write_next = op_write_reg;
    cnt_next      = cnt_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    resp_next     = resp_reg;
    resp_cnt_next = resp_cnt_reg;
    case (state_reg)
      ST_INIT: begin
        if (mem_ack) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (rx_valid && ((rx_data == CMD_WRITE) || (rx_data == CMD_READ))) begin
          op_write_next = (rx_data == CMD_WRITE);
          cnt_next      = 2'd0;
          state_next    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          addr_next = {addr_reg[23:0], rx_data};
          cnt_next  = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) state_next = op_write_reg ? ST_DATA : ST_EXEC;
        end else if (timeout_hit) begin
          state_next = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          wdata_next = {wdata_reg[23:0], rx_data};
          cnt_next   = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) state_next = ST_EXEC;
        end else if (timeout_hit) begin
          state_next = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (mem_ack) begin
          if (op_write_reg) begin
            resp_next     = {RESP_OK, 24'h000000};
            resp_cnt_next = 3'd1;
          end else begin
            resp_next     = mem_rdata;
            resp_cnt_next = 3'd4;
          end
          state_next = ST_TX;
        end
      end
      ST_TX: begin
        state_next = ST_TXW;
      end
      ST_TXW: begin
        if (tx_sent) begin
          resp_next     = {resp_reg[23:0], 8'h00};
          resp_cnt_next = resp_cnt_reg - 3'd1;
          state_next    = (resp_cnt_reg == 3'd1) ? ST_IDLE : ST_TX;
        end
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg    <= ST_INIT;
      op_write_reg <= 1'b0;
      cnt_reg      <= 2'd0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      resp_reg     <= 32'd0;
      resp_cnt_reg <= 3'd0;
    end else begin
      state_reg    <= state_next;
      op_write_reg <= op_write_next;
      cnt_reg      <= cnt_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      resp_reg     <= resp_next;
      resp_cnt_reg <= resp_cnt_next;
    end
  end

  // Outputs decode directly from the registered state, so request levels
  // and the send pulse change exactly on state transitions.
  assign mem_we    = (state_reg == ST_EXEC) && op_write_reg;
  assign mem_rd    = (state_reg == ST_EXEC) && !op_write_reg;
  assign tx_send   = (state_reg == ST_TX);
  assign tx_data   = resp_reg[31:24];
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign state     = state_reg;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb_uart_mem_bridge: directed stimulus with a scoreboard of expected UART
// reply bytes, drained by a transmitter responder process.
module tb_uart_mem_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_sent;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic        mem_rd;
  logic        mem_ack;
  logic        busy;
  logic [3:0]  state;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  uart_mem_bridge #(.TIMEOUT_CYCLES(32'd100)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_send(tx_send), .tx_sent(tx_sent),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_ack(mem_ack),
    .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1 mem_ack = 1'b1;
    @(posedge clk); #1 mem_ack = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] target, input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (state == target) break;
    end
    check(tag, state, target);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (state == 4'd1 && exp_q.size() == 0) break;
    end
    check({tag, "_idle"}, state, 4'd1);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // Transmitter model: checks each sent byte against the scoreboard, holds
  // tx_sent off for a few cycles and verifies no send overlaps a pending byte.
  initial begin
    logic follow_due;
    follow_due = 1'b0;
    tx_sent = 1'b0;
    forever begin
      @(negedge clk);
      if (follow_due) check("tx_follow", tx_send, 1'b1);
      follow_due = 1'b0;
      if (tx_send === 1'b1) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL tx_unexpected observed=%h expected=none", tx_data);
        end
        if (exp_q.size() != 0) begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("tx_data", tx_data, e);
          $display("tx byte %h (expected %h)", tx_data, e);
        end
        repeat (2) begin
          @(negedge clk);
          check("tx_send_held", tx_send, 1'b0);
        end
        @(posedge clk); #1 tx_sent = 1'b1;
        @(posedge clk); #1 tx_sent = 1'b0;
        follow_due = (exp_q.size() != 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", state, 4'd0);
    check("rst_busy", busy, 1'b1);
    check("rst_we", mem_we, 1'b0);
    check("rst_rd", mem_rd, 1'b0);
    check("rst_tx_send", tx_send, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    #1 rstn = 1'b1;

    // Bytes during calibration are discarded.
    send_byte(8'h57); send_byte(8'h00);
    @(negedge clk);
    check("init_state", state, 4'd0);
    check("init_we", mem_we, 1'b0);
    pulse_ack();
    @(negedge clk);
    check("cal_state", state, 4'd1);
    check("cal_busy", busy, 1'b0);
    $display("calibration done, state %0d", state);

    // Write command.
    exp_q.push_back(8'h4B);
    send_byte(8'h57);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    @(negedge clk);
    check("wr_we", mem_we, 1'b1);
    check("wr_rd", mem_rd, 1'b0);
    check("wr_state", state, 4'd4);
    check("wr_addr", mem_addr, 32'h0000_0100);
    check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("wr_we_held", mem_we, 1'b1);
    pulse_ack();
    @(negedge clk);
    check("wr_we_drop", mem_we, 1'b0);
    check("wr_state_tx", state, 4'd5);
    wait_idle("wr");
    $display("write 00000100 <= deadbeef done");

    // Read command, ack in the same cycle the request rises.
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    mem_rdata = 32'h1234_5678;
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    mem_ack = 1'b1;
    @(negedge clk);
    check("rd_rd", mem_rd, 1'b1);
    check("rd_we", mem_we, 1'b0);
    check("rd_addr", mem_addr, 32'h0000_0100);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rd_rd_drop", mem_rd, 1'b0);
    check("rd_state_tx", state, 4'd5);
    wait_idle("rd");
    $display("read 00000100 => 12345678 done");

    // Unknown byte and stray ack in IDLE are ignored.
    send_byte(8'h41);
    pulse_ack();
    repeat (4) @(negedge clk);
    check("unk_state", state, 4'd1);
    check("unk_q", exp_q.size(), 0);

    // Bytes arriving while the reply is in flight are dropped.
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    exp_q.push_back(8'hC3); exp_q.push_back(8'hD4);
    mem_rdata = 32'hA1B2_C3D4;
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    pulse_ack();
    wait_state(4'd6, "txw_reach");
    send_byte(8'h52);
    send_byte(8'h57);
    @(negedge clk);
    check("txw_not_addr", (state == 4'd2), 1'b0);
    wait_idle("txw");
    $display("read with dropped bytes done");

`ifdef UART_BRIDGE_TIMEOUT_EN
    // Partial write is abandoned after the gap limit.
    send_byte(8'h57); send_byte(8'h00);
    repeat (102) @(negedge clk);
    check("tmo_state", state, 4'd1);
    check("tmo_we", mem_we, 1'b0);
    send_byte(8'h52);
`else
    // Partial read waits indefinitely, then completes.
    send_byte(8'h52); send_byte(8'h00);
    repeat (102) @(negedge clk);
    check("gap_state", state, 4'd2);
`endif
    exp_q.push_back(8'h0F); exp_q.push_back(8'h1E);
    exp_q.push_back(8'h2D); exp_q.push_back(8'h3C);
    mem_rdata = 32'h0F1E_2D3C;
`ifdef UART_BRIDGE_TIMEOUT_EN
    send_byte(8'h00);
`endif
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    @(negedge clk);
    check("gap_rd", mem_rd, 1'b1);
    check("gap_addr", mem_addr, 32'h0000_0100);
    pulse_ack();
    wait_idle("gap");
    $display("gap scenario read done");

    // Reset during EXEC drops the request and requires recalibration.
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
    @(negedge clk);
    check("rexec_rd", mem_rd, 1'b1);
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    check("rexec_rd_drop", mem_rd, 1'b0);
    check("rexec_state", state, 4'd0);
    pulse_ack();
    @(negedge clk);
    check("rexec_recal", state, 4'd1);
    $display("reset during exec done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
